// File: rtl/key_pkg.sv
// Shared types and default constants for the key_debouncer slice.
// The optional long-press/auto-repeat feature is enabled by defining KEY_LONG_PRESS_EN.
package key_pkg;

    typedef enum logic [1:0] {
        KS_RELEASED    = 2'd0,
        KS_PRESS_DEB   = 2'd1,
        KS_PRESSED     = 2'd2,
        KS_RELEASE_DEB = 2'd3
    } key_state_t;

    localparam int unsigned KEY_N_KEYS       = 4;
    localparam int unsigned KEY_CLK_DIV      = 20000;
    localparam int unsigned KEY_DEB_SAMPLES  = 4;
    localparam bit          KEY_ACTIVE_LOW   = 1'b1;
    localparam int unsigned KEY_LONG_TICKS   = 1000;
    localparam int unsigned KEY_REPEAT_TICKS = 200;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: debounce FSM, debounce counter, pulse registers and,
// with KEY_LONG_PRESS_EN defined, the hold counter driving long_pulse.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES  = KEY_DEB_SAMPLES
`ifdef KEY_LONG_PRESS_EN
   ,parameter int unsigned LONG_TICKS   = KEY_LONG_TICKS
   ,parameter int unsigned REPEAT_TICKS = KEY_REPEAT_TICKS
`endif
) (
    input  logic clk,
    input  logic n_reset,
    input  logic tick,
    input  logic sample,
    output logic press,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned     CNT_W    = $clog2(DEB_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_SAMPLES - 1);

    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_press_pulse;
    logic             r_release_pulse;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned      HOLD_W      = $clog2(LONG_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LONG_TICKS - REPEAT_TICKS);

    logic [HOLD_W-1:0] r_hold;
    logic              r_long;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state         <= KS_RELEASED;
            r_cnt           <= '0;
            r_press         <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_hold          <= '0;
            r_long          <= 1'b0;
`endif
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_long          <= 1'b0;
`endif
            if (tick) begin
                case (r_state)
                    KS_RELEASED: begin
                        if (sample) begin
                            if (CNT_LAST == '0) begin
                                r_state       <= KS_PRESSED;
                                r_press       <= 1'b1;
                                r_press_pulse <= 1'b1;
                            end else begin
                                r_state <= KS_PRESS_DEB;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    KS_PRESS_DEB: begin
                        if (!sample) begin
                            r_state <= KS_RELEASED;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state       <= KS_PRESSED;
                            r_cnt         <= '0;
                            r_press       <= 1'b1;
                            r_press_pulse <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    KS_PRESSED: begin
                        if (!sample) begin
                            if (CNT_LAST == '0) begin
                                r_state         <= KS_RELEASED;
                                r_press         <= 1'b0;
                                r_release_pulse <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                                r_hold          <= '0;
`endif
                            end else begin
                                r_state <= KS_RELEASE_DEB;
                                r_cnt   <= CNT_W'(1);
                            end
                        end else begin
`ifdef KEY_LONG_PRESS_EN
                            // Reload keeps repeats REPEAT_TICKS apart after the first event.
                            if (r_hold == HOLD_LAST) begin
                                r_hold <= HOLD_RELOAD;
                                r_long <= 1'b1;
                            end else begin
                                r_hold <= r_hold + 1'b1;
                            end
`endif
                        end
                    end
                    KS_RELEASE_DEB: begin
                        if (sample) begin
                            r_state <= KS_PRESSED;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state         <= KS_RELEASED;
                            r_cnt           <= '0;
                            r_press         <= 1'b0;
                            r_release_pulse <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                            r_hold          <= '0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= KS_RELEASED;
                endcase
            end
        end
    end

    assign press         = r_press;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
`ifdef KEY_LONG_PRESS_EN
    assign long_pulse    = r_long;
`else
    assign long_pulse    = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer top: input synchronisers, shared sample prescaler, per-key channels.
// Define KEY_LONG_PRESS_EN to build the long-press/auto-repeat hold counters.
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS       = KEY_N_KEYS,
    parameter int unsigned CLK_DIV      = KEY_CLK_DIV,
    parameter int unsigned DEB_SAMPLES  = KEY_DEB_SAMPLES,
    parameter bit          ACTIVE_LOW   = KEY_ACTIVE_LOW,
    parameter int unsigned LONG_TICKS   = KEY_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = KEY_REPEAT_TICKS
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic              sample_tick
);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [N_KEYS-1:0] IDLE_LVL = {N_KEYS{ACTIVE_LOW}};

    if (N_KEYS < 1 || CLK_DIV < 2 || DEB_SAMPLES < 1 ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > LONG_TICKS) begin : g_bad_cfg
        $error("key_debouncer: invalid parameter set");
    end

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_sample;
    logic [DIV_W-1:0]  r_div;
    logic              w_tick;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= IDLE_LVL;
            r_sync2 <= IDLE_LVL;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick      = (r_div == DIV_LAST);
    assign sample_tick = w_tick;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DEB_SAMPLES  (DEB_SAMPLES)
`ifdef KEY_LONG_PRESS_EN
           ,.LONG_TICKS   (LONG_TICKS)
           ,.REPEAT_TICKS (REPEAT_TICKS)
`endif
        ) u_ch (
            .clk           (clk),
            .n_reset       (n_reset),
            .tick          (w_tick),
            .sample        (w_sample[gi]),
            .press         (press[gi]),
            .press_pulse   (press_pulse[gi]),
            .release_pulse (release_pulse[gi]),
            .long_pulse    (long_pulse[gi])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised scoreboard bench for key_debouncer; the reference model tracks accepted
// level and run length of disagreeing samples per key, with optional hold counting.
module tb_key_debouncer;

    localparam int unsigned NK   = 4;
    localparam int unsigned DIV  = 10;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 8;
    localparam int unsigned REP  = 3;
    localparam int unsigned LAT  = 2 + DIV + (DEB - 1) * DIV + 1;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] press, press_pulse, release_pulse, long_pulse;
    logic          sample_tick;

    int unsigned chk = 0;
    int unsigned err = 0;
    int unsigned lp_cnt = 0;

    key_debouncer #(
        .N_KEYS       (NK),
        .CLK_DIV      (DIV),
        .DEB_SAMPLES  (DEB),
        .ACTIVE_LOW   (1'b1),
        .LONG_TICKS   (LONG),
        .REPEAT_TICKS (REP)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .key           (key),
        .press         (press),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .sample_tick   (sample_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        time           t;
        logic [NK-1:0] pp;
        logic [NK-1:0] rp;
        logic [NK-1:0] lp;
    } ev_t;

    ev_t q[$];

    // Reference model state
    int unsigned   m_c = 0;
    logic [NK-1:0] m_d1 = '1;
    logic [NK-1:0] m_d2 = '1;
    logic [NK-1:0] m_lvl = '0;
    int unsigned   m_run[NK];
    int unsigned   m_hold[NK];

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    // A key is accepted once DEB consecutive samples disagree with the accepted level.
    always @(posedge clk or negedge n_reset) begin
        ev_t e;
        logic s;
        if (!n_reset) begin
            m_c   = 0;
            m_d1  = '1;
            m_d2  = '1;
            m_lvl = '0;
            for (int i = 0; i < NK; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
            q.delete();
        end else begin
            if (m_c == DIV - 1) begin
                e.t  = $time;
                e.pp = '0;
                e.rp = '0;
                e.lp = '0;
                for (int ch = 0; ch < NK; ch++) begin
                    s = ~m_d2[ch];
                    if (s != m_lvl[ch]) begin
                        m_run[ch]++;
                        if (m_run[ch] == DEB) begin
                            m_lvl[ch] = s;
                            m_run[ch] = 0;
                            if (s) e.pp[ch] = 1'b1;
                            else begin
                                e.rp[ch]  = 1'b1;
                                m_hold[ch] = 0;
                            end
                        end
                    end else begin
`ifdef KEY_LONG_PRESS_EN
                        if (m_lvl[ch] && m_run[ch] == 0) begin
                            m_hold[ch]++;
                            if (m_hold[ch] == LONG) begin
                                e.lp[ch]   = 1'b1;
                                m_hold[ch] = LONG - REP;
                            end
                        end
`endif
                        m_run[ch] = 0;
                    end
                end
                if ((e.pp | e.rp | e.lp) != '0) q.push_back(e);
            end
            m_c  = (m_c == DIV - 1) ? 0 : m_c + 1;
            m_d2 = m_d1;
            m_d1 = key;
        end
    end

    // Monitor: levels every cycle, pulse events popped from the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        check("sample_tick", 64'(sample_tick), 64'(m_c == DIV - 1));
        check("press_level", 64'(press), 64'(m_lvl));
        if (long_pulse[0]) lp_cnt++;
        while (q.size() > 0 && q[0].t + 5 < $time) begin
            e = q.pop_front();
            chk++;
            err++;
            $display("FAIL missed_event: got none required pp=%h rp=%h lp=%h from %0t",
                     e.pp, e.rp, e.lp, e.t);
        end
        if ((press_pulse | release_pulse | long_pulse) != '0) begin
            if (q.size() == 0) begin
                chk++;
                err++;
                $display("FAIL unexpected_pulse: got pp=%h rp=%h lp=%h required none at %0t",
                         press_pulse, release_pulse, long_pulse, $time);
            end else begin
                e = q.pop_front();
                check("event_time", 64'($time), 64'(e.t + 5));
                check("press_pulse", 64'(press_pulse), 64'(e.pp));
                check("release_pulse", 64'(release_pulse), 64'(e.rp));
                check("long_pulse", 64'(long_pulse), 64'(e.lp));
            end
        end
    end

    task automatic step(int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Returns 2 time units after a posedge on which a sample was taken.
    task automatic align();
        do step(1); while (m_c != 0);
    endtask

    task automatic wait_level(string name, int ch, logic val, int unsigned budget);
        bit seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (press[ch] === val) seen = 1'b1;
        end
        chk++;
        if (!seen) begin
            err++;
            $display("FAIL %s: press[%0d] got %b required %b within %0d clk",
                     name, ch, press[ch], val, budget);
        end
    endtask

    task automatic check_all_zero(string name);
        check({name, "_press"}, 64'(press), 64'd0);
        check({name, "_pp"}, 64'(press_pulse), 64'd0);
        check({name, "_rp"}, 64'(release_pulse), 64'd0);
        check({name, "_lp"}, 64'(long_pulse), 64'd0);
        check({name, "_tick"}, 64'(sample_tick), 64'd0);
    endtask

    initial begin
        key     = '1;
        n_reset = 1'b0;
        step(5);
        check_all_zero("reset");
        n_reset = 1'b1;
        step(25);

        key[0] = 1'b0;
        wait_level("clean_press", 0, 1'b1, LAT);
        step(20);
        key[0] = 1'b1;
        wait_level("clean_release", 0, 1'b0, LAT);
        step(20);

        align();
        key[1] = 1'b0;
        step(3 * DIV);
        key[1] = 1'b1;
        step(60);
        check("bounce_reject", 64'(press[1]), 64'd0);

        align();
        key[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(5);
            key[1] = 1'b1;
            step(1);
            key[1] = 1'b0;
            step(4);
        end
        wait_level("glitch_accept", 1, 1'b1, 5);
        key[1] = 1'b1;
        step(60);

        key = '0;
        step(60);
        check("all_pressed", 64'(press), 64'hF);
        key = '1;
        step(60);

        align();
        key[2] = 1'b0;
        step(2 * DIV + 2);
        n_reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        key[2] = 1'b1;
        step(3);
        n_reset = 1'b1;
        step(60);
        check("after_reset", 64'(press[2]), 64'd0);

        key[3] = 1'b0;
        wait_level("held_press", 3, 1'b1, LAT);
        step(5);
        n_reset = 1'b0;
        step(3);
        check("held_in_reset", 64'(press[3]), 64'd0);
        n_reset = 1'b1;
        wait_level("held_through_reset", 3, 1'b1, LAT + 2);
        key[3] = 1'b1;
        step(60);

        key[0] = 1'b0;
        wait_level("long_press", 0, 1'b1, LAT);
        lp_cnt = 0;
        step(20 * DIV + 5);
        key[0] = 1'b1;
        wait_level("long_release", 0, 1'b0, LAT);
`ifdef KEY_LONG_PRESS_EN
        check("long_count", 64'(lp_cnt), 64'd5);
`else
        check("long_count", 64'(lp_cnt), 64'd0);
`endif
        step(20);

        repeat (200) begin
            key = NK'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                n_reset = 1'b0;
                step($urandom_range(1, 4));
                n_reset = 1'b1;
            end
            step($urandom_range(1, 45));
        end
        key = '1;
        step(100);

        chk++;
        if (q.size() != 0) begin
            err++;
            $display("FAIL leftover_events: got %0d pending required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
